pc_sequencer: RTL and testbench

Program-counter stage that sits directly upstream of instruction_fetch and drives its `pc` input. It replaces the hand-driven `pc` in the top-level bench with the real next-PC logic. It consumes the fetched word `ins_mem` and the register-file operands `read_data1`/`read_data2` to resolve sequential, branch, jump and jump-register flow. It also provides stall, halt and retired-instruction bookkeeping.

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding instruction_fetch: resolves sequential, branch,
// jump and jump-register flow, with stall, halt and retired-instruction tracking.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h00000000,
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] ins_mem,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    output logic [31:0] pc,
    output logic [31:0] pc_plus1,
    output logic [1:0]  state,
    output logic        halted,
    output logic [31:0] retired_count
);

    localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] target_raw;
    logic [31:0] target;

    assign op        = ins_mem[31:26];
    assign funct     = ins_mem[5:0];
    assign imm_sext  = {{16{ins_mem[15]}}, ins_mem[15:0]};
    assign seq_pc    = pc_q + 32'd1;
    assign branch_pc = seq_pc + imm_sext;

    // Target is computed at full 32-bit width, then folded into the memory depth.
    always_comb begin
        target_raw = seq_pc;
        case (op)
            6'h04: if (read_data1 == read_data2) target_raw = branch_pc;
            6'h05: if (read_data1 != read_data2) target_raw = branch_pc;
            6'h02,
            6'h03: target_raw = {6'b0, ins_mem[25:0]};
            6'h00: if (funct == 6'h08) target_raw = read_data1;
            default: target_raw = seq_pc;
        endcase
        target = target_raw & PC_MASK;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN, ST_STALL: begin
                if (stall) begin
                    state_d = ST_STALL;
                end else if (ins_mem == HALT_WORD) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                    pc_d    = target;
                    if (cnt_q != 32'hFFFFFFFF) cnt_d = cnt_q + 32'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC & PC_MASK;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc            = pc_q;
    assign pc_plus1      = seq_pc & PC_MASK;
    assign state         = state_q;
    assign halted        = (state_q == ST_HALT);
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan steps plus random
// traffic, compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] ins_mem = 32'h0;
    logic [31:0] read_data1 = 32'h0;
    logic [31:0] read_data2 = 32'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [1:0]  state;
    logic        halted;
    logic [31:0] retired_count;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .ins_mem(ins_mem),
        .read_data1(read_data1), .read_data2(read_data2),
        .pc(pc), .pc_plus1(pc_plus1), .state(state),
        .halted(halted), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // Model: state 0=idle 1=run 2=stall 3=halt
    int          m_pc, m_st, steps;
    longint      m_cnt;
    int          total = 0;
    int          passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int model_target(input int cur, input logic [31:0] ins,
                                        input logic [31:0] a, input logic [31:0] b);
        int imm;
        imm = int'($signed(ins[15:0]));
        if (ins[31:26] == 6'h04 && a == b) return (cur + 1 + imm) % DEPTH < 0 ? (cur + 1 + imm) % DEPTH + DEPTH : (cur + 1 + imm) % DEPTH;
        if (ins[31:26] == 6'h05 && a != b) return (cur + 1 + imm) % DEPTH < 0 ? (cur + 1 + imm) % DEPTH + DEPTH : (cur + 1 + imm) % DEPTH;
        if (ins[31:26] == 6'h02 || ins[31:26] == 6'h03) return int'(ins[25:0]) % DEPTH;
        if (ins[31:26] == 6'h00 && ins[5:0] == 6'h08) return int'(a % DEPTH);
        return (cur + 1) % DEPTH;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_st = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc, 32'(m_pc));
        check({tag, ".pc_plus1"}, pc_plus1, 32'((m_pc + 1) % DEPTH));
        check({tag, ".state"}, {30'b0, state}, 32'(m_st));
        check({tag, ".halted"}, {31'b0, halted}, {31'b0, m_st == 3});
        check({tag, ".retired"}, retired_count, 32'(m_cnt));
    endtask

    task automatic step(input logic s, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b);
        stall = s; ins_mem = ins; read_data1 = a; read_data2 = b;
        if (m_st == 0) m_st = 1;
        else if (m_st != 3) begin
            if (s) m_st = 2;
            else if (ins == 32'hFFFFFFFF) m_st = 3;
            else begin
                m_pc = model_target(m_pc, ins, a, b);
                if (m_cnt < 64'hFFFFFFFF) m_cnt++;
                m_st = 1;
            end
        end
        @(posedge clk);
        #1;
        steps++;
        $display("step %0d stall=%0b ins=%h pc=%0d state=%0d retired=%0d",
                 steps, s, ins, pc, state, retired_count);
        check_all("step");
    endtask

    task automatic goto_pc(input int target_pc);
        for (int i = 0; i < 2 * DEPTH && m_pc != target_pc; i++) step(1'b0, 32'h0, 32'h0, 32'h0);
        check("goto_pc", pc, 32'(target_pc));
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst = 1'b0;
        #1;
        model_reset();
        $display("async reset applied (%s)", tag);
        check_all(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        int kind;
        steps = 0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Free-run NOPs: idle cycle, then 1..63, wrap to 0 with 64 retired
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 32'h0, 32'h0);
        check("wrap.pc", pc, 32'd0);
        check("wrap.retired", retired_count, 32'd64);

        goto_pc(5);
        step(1'b0, 32'h1022FFFE, 32'd7, 32'd7);
        check("beq_taken", pc, 32'd4);
        goto_pc(5);
        step(1'b0, 32'h1022FFFE, 32'd7, 32'd8);
        check("beq_not_taken", pc, 32'd6);
        goto_pc(2);
        step(1'b0, 32'h14220003, 32'd1, 32'd2);
        check("bne_taken", pc, 32'd6);

        goto_pc(3);
        step(1'b0, 32'h0800000A, 32'h0, 32'h0);
        check("j", pc, 32'd10);
        step(1'b0, 32'h03E00008, 32'h00000047, 32'h0);
        check("jr_masked", pc, 32'd7);

        // Stall over a taken beq, then release
        for (int i = 0; i < 3; i++) step(1'b1, 32'h10220004, 32'd3, 32'd3);
        check("stall.state", {30'b0, state}, 32'd2);
        check("stall.pc", pc, 32'd7);
        step(1'b0, 32'h10220004, 32'd3, 32'd3);
        check("stall_release.pc", pc, 32'd12);
        check("stall_release.state", {30'b0, state}, 32'd1);

        // Random traffic, never the halt word
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 5);
            w = $urandom;
            case (kind)
                0: w = {6'h04, w[25:0]};
                1: w = {6'h05, w[25:0]};
                2: w = {6'h02, w[25:0]};
                3: w = {6'h03, w[25:0]};
                4: w = {6'h00, w[25:6], 6'h08};
                default: w = {6'h08, w[25:0]};
            endcase
            step($urandom_range(0, 3) == 0, w, 32'($urandom_range(0, 3)) + (kind == 4 ? $urandom : 0),
                 32'($urandom_range(0, 3)));
        end

        // Halt: stall wins first, then halt is taken and held
        goto_pc(9);
        step(1'b1, 32'hFFFFFFFF, 32'h0, 32'h0);
        check("stall_over_halt", {30'b0, state}, 32'd2);
        step(1'b0, 32'hFFFFFFFF, 32'h0, 32'h0);
        check("halt.state", {30'b0, state}, 32'd3);
        for (int i = 0; i < 12; i++) step(i[0], $urandom & 32'h03FFFFFF, $urandom, $urandom);
        check("halt_hold.pc", pc, 32'd9);
        check("halt_hold.halted", {31'b0, halted}, 32'd1);

        async_reset_check("rst_in_halt");
        step(1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 32'h0);
        step(1'b1, 32'h0, 32'h0, 32'h0);
        step(1'b1, 32'h0, 32'h0, 32'h0);
        check("pre_rst_stall.state", {30'b0, state}, 32'd2);
        async_reset_check("rst_in_stall");
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
